dm_arbiter: RTL

Two-port arbiter and sequencer that shares the single-port synchronous data memory between the CPU MEM stage and the program/data loader. It sits between the byte-lane formatter (which supplies byte enables and lane-aligned write data) and the block RAM. It grants one requester per cycle, issues the BRAM access, and returns read data with a one-cycle-later acknowledge. It also bounds how long either requester can be starved and rejects out-of-range addresses.

---
 rtl/dm_arbiter_if.sv | 51 +++++
 rtl/dm_arbiter.sv | 138 +++++++++++++
 2 files changed

// File: rtl/dm_arbiter_if.sv
// Bus bundle shared by dm_arbiter, its two requesters (CPU MEM stage, loader)
// and the single-port data BRAM.
interface dm_arbiter_if #(
  parameter int DM_AW = 12
) ();

  logic              c_req;
  logic              c_we;
  logic [31:0]       c_addr;
  logic [3:0]        c_be;
  logic [31:0]       c_wdata;
  logic              c_gnt;
  logic              c_ack;
  logic              c_err;
  logic [31:0]       c_rdata;

  logic              l_req;
  logic              l_we;
  logic [31:0]       l_addr;
  logic [3:0]        l_be;
  logic [31:0]       l_wdata;
  logic              l_gnt;
  logic              l_ack;
  logic              l_err;
  logic [31:0]       l_rdata;

  logic              dm_en;
  logic [3:0]        dm_wea;
  logic [DM_AW-1:0]  dm_addr;
  logic [31:0]       dm_din;
  logic [31:0]       dm_dout;

  modport slave (
    input  c_req, c_we, c_addr, c_be, c_wdata,
    input  l_req, l_we, l_addr, l_be, l_wdata,
    input  dm_dout,
    output c_gnt, c_ack, c_err, c_rdata,
    output l_gnt, l_ack, l_err, l_rdata,
    output dm_en, dm_wea, dm_addr, dm_din
  );

  modport master (
    output c_req, c_we, c_addr, c_be, c_wdata,
    output l_req, l_we, l_addr, l_be, l_wdata,
    output dm_dout,
    input  c_gnt, c_ack, c_err, c_rdata,
    input  l_gnt, l_ack, l_err, l_rdata,
    input  dm_en, dm_wea, dm_addr, dm_din
  );

endinterface

// File: rtl/dm_arbiter.sv
// CPU/loader arbiter for the single-port data BRAM: one grant per cycle, ack one cycle later.
// Build option DM_ARB_RR_EN selects round-robin instead of CPU priority with starvation/burst limits.
module dm_arbiter #(
  parameter int DM_AW      = 12,
  parameter int STARVE_LIM = 4,
  parameter int MAX_BURST  = 8
) (
  input  logic        clk,
  input  logic        rstn,
  dm_arbiter_if.slave bus
);

  localparam int WAIT_W  = $clog2(STARVE_LIM + 1);
  localparam int BURST_W = $clog2(MAX_BURST + 1);
  localparam logic [WAIT_W-1:0]  WAIT_MAX  = WAIT_W'(STARVE_LIM);
  localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(MAX_BURST);

  typedef enum logic {
    OWN_C = 1'b0,
    OWN_L = 1'b1
  } owner_t;

  function automatic logic [WAIT_W-1:0] wait_sat_inc(input logic [WAIT_W-1:0] v);
    return (v == WAIT_MAX) ? v : v + 1'b1;
  endfunction

  function automatic logic [BURST_W-1:0] burst_sat_inc(input logic [BURST_W-1:0] v);
    return (v == BURST_MAX) ? v : v + 1'b1;
  endfunction

  logic [WAIT_W-1:0]  wait_cnt;
  logic [BURST_W-1:0] burst_cnt;
  owner_t             last_owner;

  logic        c_win_p0;
  logic        l_win_p0;
  logic        gnt_p0;
  logic        sel_we_p0;
  logic [31:0] sel_addr_p0;
  logic [3:0]  sel_be_p0;
  logic [31:0] sel_wdata_p0;
  logic        oor_p0;
  logic        acc_p0;

  logic        c_ack_p1;
  logic        l_ack_p1;
  logic        err_p1;
  logic        we_p1;

  logic        unused_bits;

  // p0: owner select for this cycle
  always_comb begin
    c_win_p0 = 1'b0;
    l_win_p0 = 1'b0;
    if (bus.c_req && bus.l_req) begin
`ifdef DM_ARB_RR_EN
      if (last_owner == OWN_C) l_win_p0 = 1'b1;
      else                     c_win_p0 = 1'b1;
`else
      // burst cap beats starvation so the CPU can never be locked out
      if (burst_cnt == BURST_MAX)     c_win_p0 = 1'b1;
      else if (wait_cnt == WAIT_MAX)  l_win_p0 = 1'b1;
      else                            c_win_p0 = 1'b1;
`endif
    end else if (bus.c_req) begin
      c_win_p0 = 1'b1;
    end else if (bus.l_req) begin
      l_win_p0 = 1'b1;
    end
  end

  always_comb begin
    gnt_p0       = c_win_p0 | l_win_p0;
    sel_we_p0    = l_win_p0 ? bus.l_we    : bus.c_we;
    sel_addr_p0  = l_win_p0 ? bus.l_addr  : bus.c_addr;
    sel_be_p0    = l_win_p0 ? bus.l_be    : bus.c_be;
    sel_wdata_p0 = l_win_p0 ? bus.l_wdata : bus.c_wdata;
    oor_p0       = |sel_addr_p0[31:DM_AW+2];
    acc_p0       = gnt_p0 && !oor_p0;
  end

  assign bus.c_gnt   = c_win_p0;
  assign bus.l_gnt   = l_win_p0;
  assign bus.dm_en   = acc_p0;
  assign bus.dm_wea  = (acc_p0 && sel_we_p0) ? sel_be_p0 : 4'b0000;
  assign bus.dm_addr = gnt_p0 ? sel_addr_p0[DM_AW+1:2] : '0;
  assign bus.dm_din  = gnt_p0 ? sel_wdata_p0 : 32'd0;

  // Fairness state: starvation / burst counters and last owner
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wait_cnt   <= '0;
      burst_cnt  <= '0;
      last_owner <= OWN_L;
    end else begin
`ifdef DM_ARB_RR_EN
      wait_cnt  <= '0;
      burst_cnt <= '0;
`else
      if (l_win_p0)        wait_cnt <= '0;
      else if (bus.l_req)  wait_cnt <= wait_sat_inc(wait_cnt);

      if (c_win_p0 || !bus.c_req) burst_cnt <= '0;
      else if (l_win_p0)          burst_cnt <= burst_sat_inc(burst_cnt);
`endif
      if (gnt_p0) last_owner <= l_win_p0 ? OWN_L : OWN_C;
    end
  end

  // p1: return stage, ack/err one cycle after grant
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      c_ack_p1 <= 1'b0;
      l_ack_p1 <= 1'b0;
      err_p1   <= 1'b0;
    end else begin
      c_ack_p1 <= c_win_p0;
      l_ack_p1 <= l_win_p0;
      err_p1   <= gnt_p0 && oor_p0;
    end
  end

  always_ff @(posedge clk) begin
    we_p1 <= sel_we_p0;
  end

  assign bus.c_ack   = c_ack_p1;
  assign bus.l_ack   = l_ack_p1;
  assign bus.c_err   = c_ack_p1 && err_p1;
  assign bus.l_err   = l_ack_p1 && err_p1;
  assign bus.c_rdata = (c_ack_p1 && !err_p1 && !we_p1) ? bus.dm_dout : 32'd0;
  assign bus.l_rdata = (l_ack_p1 && !err_p1 && !we_p1) ? bus.dm_dout : 32'd0;

  // Byte offset is ignored (lanes come from be); counters/owner idle in one of the modes
  assign unused_bits = ^{sel_addr_p0[1:0], last_owner, wait_cnt, burst_cnt};

endmodule
